key_debouncer: RTL
==================

// Module: key_debouncer
// PURPOSE
//   Input-side counterpart to the output pulse-stretcher. Cleans a raw button/key line (async, bouncy)
//   into a debounced level plus single-cycle press/release pulses, with optional auto-repeat pulses.
//   Sits between board inputs and the game control logic; one instance per button.
// PARAMETERS
//   STABLE_TIME    1_000_000   cycles input must be stable before press/release is accepted (>=1)
//   REPEAT_DELAY   40_000_000  cycles held after press before first repeat pulse (>=1)
//   REPEAT_PERIOD  10_000_000  cycles between subsequent repeat pulses (>=1)
//   CNT_W          26          counter width; every time parameter must be <= 2**CNT_W
// PORTS
//   clk            in   1  system clock
//   rst            in   1  reset, asynchronous, active-high
//   signal_in      in   1  raw button level, asynchronous to clk, 1 = pressed
//   repeat_en      in   1  1 = generate auto-repeat pulses while held (synchronous to clk)
//   level_out      out  1  debounced level
//   press_pulse    out  1  one-cycle pulse on accepted press
//   release_pulse  out  1  one-cycle pulse on accepted release
//   repeat_pulse   out  1  one-cycle auto-repeat pulse
// BEHAVIOUR
//   - Reset, clk and sync: reset rst, asynchronous, active-high; clock clk.
//   - rst: state IDLE, cnt 0, both sync flops 0, all outputs 0. All outputs registered.
//   - signal_in passes 2 flops -> sync_in; FSM sees only sync_in. cnt is CNT_W bits, never wraps.
//   - States:
//     IDLE:         sync_in=1 -> PRESS_WAIT, cnt<=0.
//     PRESS_WAIT:   sync_in=0 -> IDLE (bounce, no pulse).
//                   Else cnt==STABLE_TIME-1 -> PRESSED, cnt<=0, level_out<=1, press_pulse<=1.
//                   Else cnt++.
//     PRESSED:      sync_in=0 -> RELEASE_WAIT, cnt<=0.
//                   Else repeat_en=0 -> cnt<=0.
//                   Else cnt==REPEAT_DELAY-1 -> REPEAT, cnt<=0, repeat_pulse<=1. Else cnt++.
//     REPEAT:       sync_in=0 -> RELEASE_WAIT, cnt<=0.
//                   Else repeat_en=0 -> PRESSED, cnt<=0.
//                   Else cnt==REPEAT_PERIOD-1 -> cnt<=0, repeat_pulse<=1. Else cnt++.
//     RELEASE_WAIT: level_out stays 1.
//                   sync_in=1 -> PRESSED, cnt<=0 (glitch: no press pulse; repeat delay restarts).
//                   Else cnt==STABLE_TIME-1 -> IDLE, level_out<=0, release_pulse<=1. Else cnt++.
//   - Pulses are high exactly one cycle and never coincide. No repeat_pulse outside PRESSED/REPEAT.
//   - Latency: edge 1 = first clk edge sampling signal_in high (held). press_pulse/level_out rise
//     at edge STABLE_TIME+3. Release is symmetric: release_pulse/level_out fall at edge STABLE_TIME+3.
//   - A sync_in value held fewer than STABLE_TIME cycles in a *_WAIT state produces no output change.
//   - Reset mid-operation: outputs drop to 0 immediately, no release pulse. After rst falls,
//     a still-held button is re-detected as a fresh press with the normal latency.
// TESTING (STABLE_TIME=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1 Clean press, repeat_en=0: signal_in 0->1, held 30 cycles.
//     -> single press_pulse and level_out=1 at edge 7; no repeat_pulse.
//   2 Bounce: high 3 cycles, low 1, high 2, then low.
//     -> no pulses, level_out stays 0.
//   3 Release after press: signal_in 1->0 -> release_pulse, level_out=0 at edge 7 of the low.
//     Low 2 cycles then high again -> no release_pulse, no press_pulse, level_out stays 1.
//   4 Auto-repeat: repeat_en=1, hold 30 cycles.
//     -> press at edge 7; repeat_pulse at edges 17, 20, 23, 26, 29.
//   5 repeat_en 1->0 while in REPEAT.
//     -> no further repeat_pulse, level_out stays 1; release then behaves as in test 3.
//   6 rst pulse while pressed and signal_in held high.
//     -> outputs 0 during reset, no release_pulse; press_pulse at edge 7 after rst falls.

Source files
------------

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - debounced button level with press/release/auto-repeat pulses
// Two-flop synchronizer feeding a five-state qualification FSM; all outputs registered.
module key_debouncer #(
  parameter int STABLE_TIME   = 1_000_000,
  parameter int REPEAT_DELAY  = 40_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  input  logic repeat_en,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] L_STABLE_LAST = CNT_W'(STABLE_TIME - 1);
  localparam logic [CNT_W-1:0] L_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_REPEAT,
    S_RELEASE_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_repeat_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= signal_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      level_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      level_out     <= w_level_nxt;
      press_pulse   <= w_press_nxt;
      release_pulse <= w_release_nxt;
      repeat_pulse  <= w_repeat_nxt;
    end
  end

  // The counter only ever climbs to a *_LAST value before being cleared, so it cannot wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_sync2) w_state_nxt = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_STABLE_LAST) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (!repeat_en) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == L_DELAY_LAST) begin
          w_state_nxt = S_REPEAT;
          w_cnt_nxt   = '0;
        end
      end
      S_REPEAT: begin
        if (!r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (!repeat_en) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_PERIOD_LAST) begin
          w_cnt_nxt = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_STABLE_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_level_nxt   = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_REPEAT) ||
                    (w_state_nxt == S_RELEASE_WAIT);
    w_press_nxt   = (r_state == S_PRESS_WAIT) && (w_state_nxt == S_PRESSED);
    w_release_nxt = (r_state == S_RELEASE_WAIT) && (w_state_nxt == S_IDLE);
    w_repeat_nxt  = ((r_state == S_PRESSED) && (w_state_nxt == S_REPEAT)) ||
                    ((r_state == S_REPEAT) && r_sync2 && repeat_en && (r_cnt == L_PERIOD_LAST));
  end

endmodule
